mux_rr_n: RTL and testbench
===========================

Name: mux_rr_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshakes.
- Two selection modes:
  - fixed select by the `sel` port;
  - round-robin arbitration across channels.
- Output passes through one register stage and carries the source channel index.
- Used in the simulator to merge move/input streams, e.g. player 0, player 1 and AI, into a single consumer such as the board-update logic.

Parameters:
- N, default 2: number of input channels, N >= 2.
- W, default 1: data width per channel, W >= 1.
- SW, default $clog2(N): width of the select and channel-index fields. Localparam derived from N; not overridable.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, N*W: channel i occupies bits [i*W +: W].
- in_valid, input, N: per-channel data valid.
- in_ready, output, N: per-channel accept (combinational).
- mode, input, 1: 0 = fixed select, 1 = round-robin.
- sel, input, SW: channel to use in fixed mode; ignored in round-robin mode.
- o, output, W: registered output data.
- o_valid, output, 1: output register holds data.
- o_ready, input, 1: downstream accepts o this cycle.
- o_ch, output, SW: channel index that o came from.

Behaviour:
- Reset, on a rising edge with rst=1:
  - o=0, o_valid=0, o_ch=0.
  - Round-robin pointer last_gnt=N-1, so channel 0 has first priority.
  - rst overrides all handshakes in the same cycle; an in-flight output is dropped.
- Load enable:
  - ld = !o_valid | o_ready, where the second term means the slot is empty or draining this cycle.
- Grant (combinational, at most one bit set):
  - Fixed mode (mode=0): gnt[sel] = in_valid[sel]. If sel >= N, no grant.
  - Round-robin mode (mode=1): scan channels last_gnt+1, last_gnt+2, … modulo N. Grant the first channel with in_valid=1.
- Accept signal:
  - in_ready[i] = gnt[i] & ld.
  - in_ready must not depend on o_valid of the same channel beyond ld.
  - There is no combinational path from in_valid[j] to in_ready[i] in fixed mode when j != sel.
- Transfer, on a clock edge with ld=1 and any gnt:
  - o <= selected in_data.
  - o_ch <= index of the granted channel.
  - o_valid <= 1.
  - last_gnt <= index of the granted channel, in both modes.
- Drain:
  - On a clock edge with o_valid=1, o_ready=1 and no grant: o_valid <= 0.
  - o and o_ch keep their last value.
- Stall:
  - While o_valid=1 and o_ready=0, o and o_ch are held stable.
  - All in_ready = 0.
- Latency and throughput:
  - Accepted input appears on o one cycle after the accept edge.
  - Full throughput of 1 transfer per cycle when o_ready is held at 1.
- Mode switch:
  - Takes effect in the same cycle's grant evaluation.
  - last_gnt is preserved across mode changes.
- Round-robin fairness:
  - With all channels continuously valid, grants cycle 0, 1, …, N-1, 0, …
  - No channel waits more than N-1 accepted transfers.
- Wrap-around: after last_gnt=N-1, the scan starts at channel 0.
- Non-power-of-2 N: scan indices never reach values >= N.

Optional Feature:
- Macro: MUX_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 16 bits.
  - Increments each cycle that o_valid=1 and o_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared to 0 by rst only.
- Not defined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan (N=4, W=4 unless noted):
1. Reset behaviour: assert rst for 2 cycles while in_valid=4'b1111 → o=0, o_valid=0, o_ch=0, in_ready=0 in the cycle after the reset edge. After release in round-robin mode, channel 0 is granted first.
2. Fixed mode, mode=0, sel=2:
   - Stimulus: in_data = {4'hD, 4'hC, 4'hB, 4'hA}, in_valid=4'b1111, o_ready=1.
   - Expected: in_ready=4'b0100. Next cycle o=4'hC, o_ch=2, o_valid=1.
   - sel=3 with in_valid[3]=0 → no transfer; o_valid drops to 0 after drain.
3. Round-robin mode, all valid: mode=1, in_valid=4'b1111, o_ready=1 for 8 cycles → o_ch sequence 0,1,2,3,0,1,2,3 and o sequence A,B,C,D,A,B,C,D.
4. Round-robin skip and wrap: last_gnt=1 and in_valid=4'b0001 → channel 0 granted (wrap), and the following grant search starts at 1.
5. Backpressure:
   - o_valid=1 with o=4'hB, then o_ready=0 for 3 cycles → o=4'hB held, in_ready=0.
   - With MUX_STALL_CNT_EN defined: stall_cnt goes 0→3.
   - o_ready=1 → next data loads the same edge.
6. Non-power-of-2 and overflow cases:
   - N=3, W=2, mode=0, sel=3 → no grant, in_ready=0.
   - mode=1 with all valid → o_ch cycles 0,1,2.
   - With MUX_STALL_CNT_EN and 70000 stall cycles → stall_cnt=16'hFFFF.

Source files
------------

// File: rtl/mux_rr_n.sv
// N-channel registered mux (fixed select or round-robin); 1-cycle latency, in_ready drops while output stalls.
// Optional stall counter port enabled by defining MUX_STALL_CNT_EN.
module mux_rr_n #(
    parameter int N = 2,
    parameter int W = 1,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    output logic [W-1:0]   o,
    output logic           o_valid,
    input  logic           o_ready,
    output logic [SW-1:0]  o_ch
`ifdef MUX_STALL_CNT_EN
    ,
    output logic [15:0]    stall_cnt
`endif
);

    logic [W-1:0]  o_q;
    logic          o_valid_q;
    logic [SW-1:0] o_ch_q;
    logic [SW-1:0] last_gnt_q;

    logic [N-1:0]  gnt;
    logic          any_gnt;
    logic          ld;
    logic [SW-1:0] gnt_idx;
    logic [W-1:0]  gnt_dat;
    logic          found;
    int            idx;

    assign ld      = !o_valid_q || o_ready;
    assign any_gnt = |gnt;

    // Fixed mode only looks at in_valid[sel]; round-robin scans from last_gnt+1 with wrap at N.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (sel == SW'(i)) begin
                    gnt[i] = in_valid[i];
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                idx = int'(last_gnt_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!found && in_valid[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        gnt_dat = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = SW'(i);
                gnt_dat = in_data[i*W +: W];
            end
        end
    end

    // Reset suppresses every handshake so nothing is accepted on a reset edge.
    assign in_ready = (ld && !rst) ? gnt : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q        <= '0;
            o_valid_q  <= 1'b0;
            o_ch_q     <= '0;
            last_gnt_q <= SW'(N - 1);
        end else if (ld && any_gnt) begin
            o_q        <= gnt_dat;
            o_valid_q  <= 1'b1;
            o_ch_q     <= gnt_idx;
            last_gnt_q <= gnt_idx;
        end else if (ld) begin
            o_valid_q  <= 1'b0;
        end
    end

    assign o       = o_q;
    assign o_valid = o_valid_q;
    assign o_ch    = o_ch_q;

`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (o_valid_q && !o_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: N=4/W=4 instance against a reference model plus scoreboard, and an N=3/W=2 instance.
module tb_mux_rr_n;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  o;
    logic        o_valid;
    logic        o_ready;
    logic [1:0]  o_ch;

    logic [5:0]  b_in_data;
    logic [2:0]  b_in_valid;
    logic [2:0]  b_in_ready;
    logic        b_mode;
    logic [1:0]  b_sel;
    logic [1:0]  b_o;
    logic        b_o_valid;
    logic        b_o_ready;
    logic [1:0]  b_o_ch;

`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] b_stall_cnt;
`endif

    always #5 clk = ~clk;

    mux_rr_n #(.N(4), .W(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel), .o(o), .o_valid(o_valid), .o_ready(o_ready), .o_ch(o_ch)
`ifdef MUX_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    mux_rr_n #(.N(3), .W(2)) dut_b (
        .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .mode(b_mode), .sel(b_sel), .o(b_o), .o_valid(b_o_valid), .o_ready(b_o_ready), .o_ch(b_o_ch)
`ifdef MUX_STALL_CNT_EN
        , .stall_cnt(b_stall_cnt)
`endif
    );

    typedef struct {
        logic [3:0] d;
        logic [1:0] ch;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         m_last;
    bit         m_vld;
    logic [3:0] m_o;
    logic [1:0] m_ch;

    localparam logic [15:0] DAT = {4'hD, 4'hC, 4'hB, 4'hA};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; mode = 1'b1; in_valid = 4'b1111; o_ready = 1'b1; in_data = DAT;
        b_in_valid = 3'b111; b_mode = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_o", o, 0);
            chk("rst_o_valid", o_valid, 0);
            chk("rst_o_ch", o_ch, 0);
            chk("rst_in_ready", in_ready, 0);
        end
        rst = 1'b0;
        in_valid = 4'b0000; b_in_valid = 3'b000;
        m_last = 3; m_vld = 0; m_o = 4'h0; m_ch = 2'd0;
        sb_q.delete();
    endtask

    // One cycle on the N=4 instance: model predicts grant, pushes expected output, then compares.
    task automatic step(input logic md, input logic [1:0] s, input logic [3:0] v,
                        input logic ordy, input logic [15:0] dat);
        bit   ld;
        int   g;
        exp_t e;
        mode = md; sel = s; in_valid = v; o_ready = ordy; in_data = dat;
        ld = !m_vld || ordy;
        g  = -1;
        if (!md) begin
            if (v[s]) g = int'(s);
        end else begin
            for (int k = 1; k <= 4; k++) begin
                int ix;
                ix = (m_last + k) % 4;
                if (g < 0 && v[ix]) g = ix;
            end
        end
        #1;
        chk("in_ready", in_ready, (g >= 0 && ld) ? (32'd1 << g) : 32'd0);
        if (g >= 0 && ld) begin
            e.d  = dat[g*4 +: 4];
            e.ch = 2'(g);
            sb_q.push_back(e);
            m_last = g;
            m_vld  = 1;
        end else if (ld) begin
            m_vld = 0;
        end
        @(posedge clk); #1;
        chk("o_valid", o_valid, m_vld);
        if (g >= 0 && ld) begin
            if (sb_q.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb_q.pop_front();
                m_o = e.d;
                m_ch = e.ch;
            end
        end
        chk("o", o, m_o);
        chk("o_ch", o_ch, m_ch);
    endtask

    initial begin
        rst = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = '0; in_data = DAT; o_ready = 1'b1;
        b_in_data = {2'd3, 2'd2, 2'd1}; b_in_valid = '0; b_mode = 1'b0; b_sel = 2'd0; b_o_ready = 1'b1;

        // Reset, then round-robin starts at channel 0
        do_reset();
        step(1'b1, 2'd0, 4'b1111, 1'b1, DAT);
        chk("first_rr_ch", o_ch, 0);

        // Fixed select
        do_reset();
        step(1'b0, 2'd2, 4'b1111, 1'b1, DAT);
        chk("fixed_o", o, 4'hC);
        chk("fixed_ch", o_ch, 2);
        step(1'b0, 2'd3, 4'b0111, 1'b1, DAT);
        chk("fixed_drain", o_valid, 0);

        // Round-robin, all valid
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'd0, 4'b1111, 1'b1, DAT);
            chk("rr_seq_ch", o_ch, k % 4);
            chk("rr_seq_o", o, 4'hA + (k % 4));
        end

        // Skip and wrap: last_gnt=1 via fixed mode, then only channel 0 valid
        do_reset();
        step(1'b0, 2'd1, 4'b0010, 1'b1, DAT);
        step(1'b1, 2'd0, 4'b0001, 1'b1, DAT);
        chk("wrap_ch", o_ch, 0);
        step(1'b1, 2'd0, 4'b1111, 1'b1, DAT);
        chk("after_wrap_ch", o_ch, 1);

        // Backpressure
        do_reset();
        step(1'b0, 2'd1, 4'b1111, 1'b1, DAT);
        chk("bp_load", o, 4'hB);
`ifdef MUX_STALL_CNT_EN
        chk("stall_cnt0", stall_cnt, 0);
`endif
        repeat (3) step(1'b1, 2'd0, 4'b1111, 1'b0, 16'h5678);
        chk("bp_hold", o, 4'hB);
`ifdef MUX_STALL_CNT_EN
        chk("stall_cnt3", stall_cnt, 3);
`endif
        step(1'b1, 2'd0, 4'b1111, 1'b1, 16'h5678);
        chk("bp_release_ch", o_ch, 2);
        step(1'b1, 2'd0, 4'b0110, 1'b1, 16'h5678);
        step(1'b0, 2'd0, 4'b1110, 1'b1, 16'h5678);

        // N=3, W=2 instance
        do_reset();
        b_mode = 1'b0; b_sel = 2'd3; b_in_valid = 3'b111; b_o_ready = 1'b1;
        #1;
        chk("n3_sel3_rdy", b_in_ready, 0);
        @(posedge clk); #1;
        chk("n3_sel3_vld", b_o_valid, 0);
        b_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("n3_rr_rdy", b_in_ready, 32'd1 << (k % 3));
            @(posedge clk); #1;
            chk("n3_rr_ch", b_o_ch, k % 3);
            chk("n3_rr_o", b_o, (k % 3) + 1);
        end
        b_in_valid = 3'b000;

`ifdef MUX_STALL_CNT_EN
        // Saturation
        do_reset();
        step(1'b0, 2'd0, 4'b0001, 1'b1, DAT);
        in_valid = 4'b0000; o_ready = 1'b0;
        repeat (70000) @(posedge clk);
        #1;
        chk("stall_sat", stall_cnt, 16'hFFFF);
        o_ready = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
